// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and types for the UART FIFO datapath.
//   UART_DATA_W        default FIFO data width
//   UART_FIFO_DEPTH    default FIFO depth (power of two)
//   uart_fifo_status_t status bundle consumed by the register block
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic thresh;
    logic overflow;
    logic underflow;
  } uart_fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W storage for uart_fifo_sync.
// One synchronous write port and one registered read port. The array itself
// is not reset so it can be replaced by a macro RAM; only the read register is.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset (read register only)
//   wr_en_i           write strobe
//   wr_addr_i         write address
//   wr_data_i         write data
//   rd_en_i           read strobe, loads rd_data_o from rd_addr_i
//   rd_addr_i         read address
//   rd_data_o         registered read data, holds when rd_en_i is low
module uart_fifo_mem #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Read-before-write: a same-address write in the same cycle returns old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/uart_fifo_sync.sv
// uart_fifo_sync: parametrised synchronous FIFO for the UART TX/RX datapaths.
// Build option: define UART_FIFO_STICKY_ERR_EN to make overflow_o/underflow_o
// sticky until clear_i or reset; otherwise they are one-cycle pulses.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         synchronous flush (priority over reads and writes)
//   wr_en_i, data_i write request and data
//   rd_en_i         read request; data_o valid one clock later
//   data_o          registered read data, rd_valid_o marks an update
//   full_o, empty_o occupancy flags, level_o occupancy 0..DEPTH
//   thresh_i        threshold (0 disables), thresh_o = level_o >= thresh_i
//   overflow_o      write attempted while full with no read accepted
//   underflow_o     read attempted while empty
module uart_fifo_sync
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_W = UART_DATA_W,
  parameter  int unsigned DEPTH  = UART_FIFO_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o,
  input  logic [AW:0]       thresh_i,
  output logic              thresh_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              rd_valid;
  logic              ovf_q;
  logic              unf_q;
  uart_fifo_status_t status;

  logic rd_acc, wr_acc, rd_go, wr_go, ovf_ev, unf_ev;

  always_comb begin
    status           = '0;
    status.full      = (level == LVL_FULL);
    status.empty     = (level == '0);
    status.thresh    = (thresh_i != '0) && (level >= thresh_i);
    status.overflow  = ovf_q;
    status.underflow = unf_q;
  end

  // A read frees a slot in the same cycle, so a write at full is accepted
  // together with a read.
  always_comb begin
    rd_acc = rd_en_i && !status.empty;
    wr_acc = wr_en_i && (!status.full || rd_acc);
    rd_go  = rd_acc && !clear_i;
    wr_go  = wr_acc && !clear_i;
    ovf_ev = wr_en_i && status.full && !rd_acc;
    unf_ev = rd_en_i && status.empty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      rd_valid <= rd_acc;
`ifdef UART_FIFO_STICKY_ERR_EN
      ovf_q    <= ovf_q | ovf_ev;
      unf_q    <= unf_q | unf_ev;
`else
      ovf_q    <= ovf_ev;
      unf_q    <= unf_ev;
`endif
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_go),
    .wr_addr_i (wr_ptr),
    .wr_data_i (data_i),
    .rd_en_i   (rd_go),
    .rd_addr_i (rd_ptr),
    .rd_data_o (data_o)
  );

  assign rd_valid_o  = rd_valid;
  assign level_o     = level;
  assign full_o      = status.full;
  assign empty_o     = status.empty;
  assign thresh_o    = status.thresh;
  assign overflow_o  = status.overflow;
  assign underflow_o = status.underflow;

endmodule

// File: doc/uart_fifo_sync.md
Name: uart_fifo_sync

Overview:
- Parametrised synchronous FIFO for the UART TX and RX datapaths; successor to the fixed 8x8 TX FIFO.
- Generic data width and power-of-two depth.
- Correct full/empty under wrap-around, occupancy count and a programmable threshold flag.
- Defined simultaneous read/write, synchronous flush and registered read data.
- Sits between the TL-UL register interface (write side) and the UART TX shifter (read side); the same block is instanced mirrored for RX.

Parameters:
- DATA_W, 8, data word width in bits (1..32).
- DEPTH, 16, number of entries; power of two, 2..256.
- AW, $clog2(DEPTH), pointer width; derived, not to be overridden.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush, one-cycle pulse.
- wr_en_i  in  1  write request.
- data_i  in  DATA_W  write data.
- rd_en_i  in  1  read request.
- data_o  out  DATA_W  registered read data.
- rd_valid_o  out  1  data_o updated this cycle by an accepted read.
- full_o  out  1  level == DEPTH.
- empty_o  out  1  level == 0.
- level_o  out  AW+1  current occupancy, 0..DEPTH.
- thresh_i  in  AW+1  threshold level; 0 disables.
- thresh_o  out  1  (level_o >= thresh_i) && (thresh_i != 0).
- overflow_o  out  1  write attempted while full and no read accepted.
- underflow_o  out  1  read attempted while empty.

Behaviour:
- Reset (async, rst_ni low):
  - wr_ptr = rd_ptr = 0, level = 0.
  - data_o = 0, rd_valid_o = 0.
  - full_o = 0, empty_o = 1, thresh_o = 0.
  - overflow_o = underflow_o = 0.
  - Memory contents are not reset; data_o stays 0 until the first accepted read.
  - Reset mid-operation discards all contents immediately.
- Pointers are AW bits and wrap naturally from DEPTH-1 to 0. level is a separate AW+1 counter, so full and empty are unambiguous.
- Read accept (rd_acc): rd_en_i && !empty_o.
  - data_o <= mem[rd_ptr] at the same edge; rd_ptr increments.
  - rd_valid_o = 1 in the following cycle. Read latency is 1 clock.
- Write accept (wr_acc): wr_en_i && (!full_o || rd_acc).
  - mem[wr_ptr] <= data_i; wr_ptr increments.
- level update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- Simultaneous read/write:
  - When full: both accepted, level stays DEPTH, full_o stays 1.
  - When empty: write accepted, read rejected, level becomes 1, rd_valid_o = 0, underflow flagged.
- clear_i has priority over wr_en_i and rd_en_i.
  - Pointers and level go to 0; rd_valid_o = 0 next cycle.
  - data_o holds its last value.
  - Error flags are cleared.
- full_o, empty_o and thresh_o are combinational from registered level_o and thresh_i; no extra latency.
- thresh_i may change at any time; thresh_o follows in the same cycle.
- overflow_o and underflow_o are single-cycle pulses, registered and asserted the cycle after the offending request. Rejected requests never modify state.

Optional Feature:
- Macro: UART_FIFO_STICKY_ERR_EN.
- Defined: overflow_o and underflow_o are sticky. Once set they stay 1 until clear_i or reset.
- Undefined: they are one-cycle pulses as described above.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W default (8).
  - UART_FIFO_DEPTH default (16).
  - typedef uart_fifo_status_t, a packed struct {full, empty, thresh, overflow, underflow} used by the register block.
- Sub-module uart_fifo_mem: DEPTH x DATA_W storage array.
  - One write port, one registered read port.
  - No reset on the array.
  - Kept separate so it can be swapped for a macro RAM.
- Pointer, level and flag logic stays in uart_fifo_sync.

Test Plan (DEPTH=16, DATA_W=8):
- Reset, then write 0x01..0x10 on 16 cycles -> level_o 16, full_o 1. A 17th write of 0xAA -> overflow_o pulse, level_o stays 16.
- From full, read 16 times -> data_o 0x01..0x10 in order, each one cycle after rd_en_i. Then empty_o 1; a further read -> underflow_o pulse, rd_valid_o 0.
- Wrap-around: write 10, read 10, write 12, read 12 -> data intact across the pointer wrap, level_o returns to 0.
- Simultaneous wr/rd at level 16 and at level 0:
  - At 16: level_o stays 16, data_o shows the oldest entry.
  - At 0: level_o becomes 1, rd_valid_o 0.
- thresh_i=4: level_o goes 3 -> 4 -> thresh_o rises in the same cycle. Set thresh_i=0 -> thresh_o 0.
- clear_i asserted at level 9 together with wr_en_i -> level_o 0, empty_o 1, write ignored. With UART_FIFO_STICKY_ERR_EN, a prior overflow_o is held until this clear, then drops.
